sram_rr_arbiter: RTL

- Single-clock, parametrised round-robin arbitration core for the SRAM controller port.
- Arbitrates NUM_WR write channels and NUM_RD read channels onto one SRAM command interface.
- Tracks outstanding reads with an in-order tag FIFO and routes returned data to the requesting read port.
- Per-port credit counters guarantee downstream read-data buffers never overflow. Clock-crossing FIFOs sit outside this block.

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/rr_grant.sv | 33 +++
 rtl/sram_rr_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and width helpers for the SRAM round-robin arbiter.
package sram_arb_pkg;

  // err_sticky bit positions
  localparam int ERR_ORPHAN = 0;
  localparam int ERR_CREDIT = 1;
  localparam int ERR_W      = 2;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width for an n-entry space; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// N-way round-robin picker: first requester strictly after 'last', wrapping.
module rr_grant
  import sram_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int   c;
  logic found;

  // Scan offsets 1..N from last; offset N revisits last itself
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter of write and read channels onto one SRAM command port,
// with in-order read tag tracking and per-read-port credit flow control.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_WR          = 2,
  parameter int NUM_RD          = 2,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 32,
  parameter int MASK_W          = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RD_CREDITS      = 4
) (
  input  logic                     sram_clock,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_valid,
  output logic [NUM_WR-1:0]        wr_ready,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*MASK_W-1:0] wr_mask,
  input  logic [NUM_RD-1:0]        rd_req_valid,
  output logic [NUM_RD-1:0]        rd_req_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_resp_valid,
  output logic [DATA_W-1:0]        rd_resp_data,
  input  logic [NUM_RD-1:0]        rd_credit_return,
  input  logic                     sram_ready,
  output logic                     sram_addr_valid,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [DATA_W-1:0]        sram_data_in,
  output logic [MASK_W-1:0]        sram_write_mask,
  input  logic [DATA_W-1:0]        sram_data_out,
  input  logic                     sram_data_out_valid,
  output logic [ERR_W-1:0]         err_sticky
);

  localparam int NCH   = NUM_WR + NUM_RD;
  localparam int IDX_W = idx_w(NCH);
  localparam int TAG_W = idx_w(NUM_RD);
  localparam int PTR_W = idx_w(MAX_OUTSTANDING);
  localparam int CNT_W = clog2(MAX_OUTSTANDING + 1);
  localparam int CR_W  = clog2(RD_CREDITS + 1);

  // Arbitration state
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [NCH-1:0]    req, gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [NUM_RD-1:0] rd_elig, rd_gnt;
  logic              cmd_free, grant_en, any_gnt;

  // Command register
  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [MASK_W-1:0] cmd_mask_q, cmd_mask_d;

  // Tag FIFO
  logic [TAG_W-1:0]  tag_mem_q [MAX_OUTSTANDING];
  logic [TAG_W-1:0]  tag_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_full, push, pop;
  logic [TAG_W-1:0]  push_tag, head_tag;

  // Credits, return path, errors
  logic [CR_W-1:0]   credit_q [NUM_RD];
  logic [CR_W-1:0]   credit_d [NUM_RD];
  logic [NUM_RD-1:0] resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [ERR_W-1:0]  err_q, err_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full is judged on the registered count, so a pop frees a slot next cycle
  assign fifo_full = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign cmd_free  = ~cmd_valid_q | sram_ready;
  assign grant_en  = ~reset & sram_ready & cmd_free;

  // Read eligibility: request, spare credit, room for its tag
  always_comb begin
    rd_elig = '0;
    for (int j = 0; j < NUM_RD; j++)
      rd_elig[j] = rd_req_valid[j] & (credit_q[j] != '0) & ~fifo_full;
  end

  assign req = grant_en ? {rd_elig, wr_valid} : '0;

  rr_grant #(.N(NCH), .IDX_W(IDX_W)) u_rr (
    .req     (req),
    .last    (last_grant_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt      = |gnt;
  assign wr_ready     = gnt[NUM_WR-1:0];
  assign rd_gnt       = gnt[NCH-1:NUM_WR];
  assign rd_req_ready = rd_gnt;
  assign last_grant_d = any_gnt ? gnt_idx : last_grant_q;

  // Load the command register from the winner; drop valid once consumed
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_mask_d  = cmd_mask_q;
    push        = 1'b0;
    push_tag    = '0;
    if (any_gnt) begin
      cmd_valid_d = 1'b1;
      for (int i = 0; i < NUM_WR; i++) begin
        if (gnt[i]) begin
          cmd_addr_d = wr_addr[i*ADDR_W +: ADDR_W];
          cmd_data_d = wr_data[i*DATA_W +: DATA_W];
          cmd_mask_d = wr_mask[i*MASK_W +: MASK_W];
        end
      end
      for (int j = 0; j < NUM_RD; j++) begin
        if (rd_gnt[j]) begin
          cmd_addr_d = rd_addr[j*ADDR_W +: ADDR_W];
          cmd_data_d = '0;
          cmd_mask_d = '0;
          push       = 1'b1;
          push_tag   = TAG_W'(j);
        end
      end
    end else if (sram_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  assign pop      = sram_data_out_valid & (count_q != '0);
  assign head_tag = tag_mem_q[rd_ptr_q];

  // Tag FIFO, response routing, credit accounting and sticky errors
  always_comb begin
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    err_d        = err_q;
    credit_d     = credit_q;

    if (push) begin
      tag_mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      resp_data_d = sram_data_out;
      for (int j = 0; j < NUM_RD; j++)
        resp_valid_d[j] = (head_tag == TAG_W'(j));
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Data with no tag in flight has nowhere to go
    if (sram_data_out_valid && (count_q == '0))
      err_d[ERR_ORPHAN] = 1'b1;

    for (int j = 0; j < NUM_RD; j++) begin
      if (rd_gnt[j] && !rd_credit_return[j]) begin
        credit_d[j] = credit_q[j] - CR_W'(1);
      end else if (!rd_gnt[j] && rd_credit_return[j]) begin
        if (credit_q[j] == CR_W'(RD_CREDITS))
          err_d[ERR_CREDIT] = 1'b1;
        else
          credit_d[j] = credit_q[j] + CR_W'(1);
      end
    end
  end

  // State update; reset abandons anything in flight
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NCH - 1);
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      cmd_mask_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= '0;
      for (int t = 0; t < MAX_OUTSTANDING; t++) tag_mem_q[t] <= '0;
      for (int j = 0; j < NUM_RD; j++) credit_q[j] <= CR_W'(RD_CREDITS);
    end else begin
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      cmd_mask_q   <= cmd_mask_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
      tag_mem_q    <= tag_mem_d;
      credit_q     <= credit_d;
    end
  end

  assign sram_addr_valid = cmd_valid_q;
  assign sram_addr       = cmd_addr_q;
  assign sram_data_in    = cmd_data_q;
  assign sram_write_mask = cmd_mask_q;
  assign rd_resp_valid   = resp_valid_q;
  assign rd_resp_data    = resp_data_q;
  assign err_sticky      = err_q;

endmodule
